// File: rtl/cpc_eeprom_write_seq.sv
// In-system programming sequencer for the 28C256 EEPROM pairs on the
// eight-ROM board. Snoops Z80 writes to &C000-&FFFF and, once unlocked via
// the I/O port, turns each one into a fixed-width write-enable pulse. It
// also enforces the page-load window and the internal write-cycle time.
module cpc_eeprom_write_seq #(
  parameter logic [7:0]  PORT_HI      = 8'hDD,
  parameter int unsigned WE_CYCLES    = 2,
  parameter int unsigned PAGE_TIMEOUT = 400,
  parameter int unsigned WRITE_CYCLES = 40000
) (
  input  logic        CLK,
  input  logic        RESET_B,
  input  logic [15:0] A,
  input  logic [7:0]  D,
  input  logic        MREQ_B,
  input  logic        IOREQ_B,
  input  logic        RD_B,
  input  logic        WR_B,
  input  logic [3:0]  rom_sel,
  input  logic        sel_valid,
  output logic [3:0]  we_b,
  output logic [7:0]  dout,
  output logic        dout_en
);

  // Reload values are clamped to 1 so a running counter is never reloaded with 0.
  localparam logic [15:0] WE_LD = 16'((WE_CYCLES    == 0) ? 1 : WE_CYCLES);
  localparam logic [15:0] PT_LD = 16'((PAGE_TIMEOUT == 0) ? 1 : PAGE_TIMEOUT);
  localparam logic [15:0] WC_LD = 16'((WRITE_CYCLES == 0) ? 1 : WRITE_CYCLES);

  typedef enum logic [1:0] {LK_LOCKED, LK_HALF, LK_OPEN} lock_t;
  typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_LOAD, ST_PROG} state_t;

  lock_t       lock_q, lock_d;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  page_q, page_d;
  logic [1:0]  pair_q, pair_d;
  logic        err_q, err_d;
  logic [3:0]  we_b_q, we_b_d;
  logic [7:0]  dout_q, dout_d;
  logic        io_wr_prev_q, mw_prev_q;

  logic io_wr_c, mw_c, io_wr, det;
  logic is_open, match, last;
  logic err_set, err_clr;

  logic unused_ok;
  assign unused_ok = ^{A[5:0], rom_sel[3], rom_sel[0]};

  assign io_wr_c = !IOREQ_B && !WR_B && (A[15:8] == PORT_HI);
  assign mw_c    = !MREQ_B && !WR_B && (A[15:14] == 2'b11) && sel_valid;
  assign io_wr   = io_wr_c && !io_wr_prev_q;
  assign det     = mw_c && !mw_prev_q;
  assign is_open = (lock_q == LK_OPEN);
  assign match   = (A[13:6] == page_q) && (rom_sel[2:1] == pair_q);
  assign last    = (cnt_q == 16'd1);

  // Unlock sequence: &A5 then &5A opens; &00 relocks from anywhere and clears err.
  always_comb begin
    lock_d  = lock_q;
    err_clr = 1'b0;
    if (io_wr) begin
      if (D == 8'h00) begin
        lock_d  = LK_LOCKED;
        err_clr = 1'b1;
      end else begin
        case (lock_q)
          LK_LOCKED: if (D == 8'hA5) lock_d = LK_HALF;
          LK_HALF:   lock_d = (D == 8'h5A) ? LK_OPEN : LK_LOCKED;
          default:   lock_d = lock_q;
        endcase
      end
    end
  end

  // Write sequencing: pulse, page-load window, then programming time.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    pair_d  = pair_q;
    err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (det && is_open) begin
          state_d = ST_PULSE;
          cnt_d   = WE_LD;
          page_d  = A[13:6];
          pair_d  = rom_sel[2:1];
        end
      end
      ST_PULSE: begin
        if (last) begin
          if (det && is_open && match) begin
            cnt_d = WE_LD;
          end else begin
            state_d = ST_LOAD;
            cnt_d   = PT_LD;
            err_set = det && is_open;
          end
        end else begin
          cnt_d   = cnt_q - 16'd1;
          err_set = det && is_open;
        end
      end
      ST_LOAD: begin
        if (last) begin
          // A byte landing on the expiry edge is too late for this page.
          state_d = ST_PROG;
          cnt_d   = WC_LD;
          err_set = det;
        end else if (det && is_open && match) begin
          state_d = ST_PULSE;
          cnt_d   = WE_LD;
        end else begin
          cnt_d   = cnt_q - 16'd1;
          err_set = det && is_open;
        end
      end
      ST_PROG: begin
        err_set = det;
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Registered outputs: one-hot-low write enable and the status byte.
  always_comb begin
    err_d  = err_clr ? 1'b0 : (err_q | err_set);
    we_b_d = (state_q == ST_PULSE) ? ~(4'b0001 << pair_q) : 4'hF;
    dout_d = {(state_d != ST_IDLE), err_d, (lock_d == LK_OPEN), 5'b0};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_B) begin
      lock_q       <= LK_LOCKED;
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      page_q       <= 8'h00;
      pair_q       <= 2'd0;
      err_q        <= 1'b0;
      we_b_q       <= 4'hF;
      dout_q       <= 8'h00;
      io_wr_prev_q <= 1'b0;
      mw_prev_q    <= 1'b0;
    end else begin
      lock_q       <= lock_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      page_q       <= page_d;
      pair_q       <= pair_d;
      err_q        <= err_d;
      we_b_q       <= we_b_d;
      dout_q       <= dout_d;
      io_wr_prev_q <= io_wr_c;
      mw_prev_q    <= mw_c;
    end
  end

  assign we_b    = we_b_q;
  assign dout    = dout_q;
  assign dout_en = !IOREQ_B && !RD_B && (A[15:8] == PORT_HI);

endmodule

// File: tb/tb_cpc_eeprom_write_seq.sv
// Bench for cpc_eeprom_write_seq: deadline-based reference model, per-cycle
// compare process, directed scenarios with literal expectations, then
// randomized bus traffic.
module tb_cpc_eeprom_write_seq;
  localparam int WE = 2;
  localparam int PT = 400;
  localparam int WC = 1000;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [7:0]  d = 8'h00;
  logic        mreq_b = 1'b1, ioreq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1;
  logic [3:0]  rom_sel = 4'd0;
  logic        sel_valid = 1'b1;
  logic [3:0]  we_b;
  logic [7:0]  dout;
  logic        dout_en;

  cpc_eeprom_write_seq #(
    .PORT_HI(8'hDD), .WE_CYCLES(WE), .PAGE_TIMEOUT(PT), .WRITE_CYCLES(WC)
  ) dut (
    .CLK(clk), .RESET_B(reset_b), .A(a), .D(d),
    .MREQ_B(mreq_b), .IOREQ_B(ioreq_b), .RD_B(rd_b), .WR_B(wr_b),
    .rom_sel(rom_sel), .sel_valid(sel_valid),
    .we_b(we_b), .dout(dout), .dout_en(dout_en)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the sequence is described by the edge numbers at which
  // the pulse, the load window and the programming time end.
  int t = 0;
  int pulse_until = 0, load_until = 0, prog_until = 0;
  logic [7:0] m_page = 8'h00;
  logic [1:0] m_pair = 2'd0;
  int m_lock = 0;            // 0 locked, 1 half, 2 open
  bit m_err = 1'b0;
  bit io_prev = 1'b0, md_prev = 1'b0;
  logic [3:0] exp_we = 4'hF;
  logic [7:0] exp_dout = 8'h00;

  function automatic int phase(input int x);
    if (x < pulse_until) return 1;
    if (x < load_until)  return 2;
    if (x < prog_until)  return 3;
    return 0;
  endfunction

  task automatic start_pulse(input int e);
    pulse_until = e + WE;
    load_until  = pulse_until + PT;
    prog_until  = load_until + WC;
  endtask

  task automatic model_step();
    bit io_c, md_c, ioa, det, open, match;
    int ph;
    t++;
    if (!reset_b) begin
      pulse_until = 0; load_until = 0; prog_until = 0;
      m_lock = 0; m_err = 1'b0; io_prev = 1'b0; md_prev = 1'b0;
      exp_we = 4'hF; exp_dout = 8'h00;
      return;
    end
    io_c = !ioreq_b && !wr_b && (a[15:8] == 8'hDD);
    md_c = !mreq_b && !wr_b && (a[15:14] == 2'b11) && sel_valid;
    ioa = io_c && !io_prev;
    det = md_c && !md_prev;
    io_prev = io_c;
    md_prev = md_c;
    ph = phase(t - 1);
    exp_we = (ph == 1) ? ~(4'b0001 << m_pair) : 4'hF;
    open  = (m_lock == 2);
    match = (a[13:6] == m_page) && (rom_sel[2:1] == m_pair);
    if (det) begin
      case (ph)
        0: if (open) begin m_page = a[13:6]; m_pair = rom_sel[2:1]; start_pulse(t); end
        1: begin
             if (t == pulse_until && open && match) start_pulse(t);
             else if (open) m_err = 1'b1;
           end
        2: begin
             if (t == load_until) m_err = 1'b1;
             else if (open) begin
               if (match) start_pulse(t); else m_err = 1'b1;
             end
           end
        default: m_err = 1'b1;
      endcase
    end
    if (ioa) begin
      if (d == 8'h00) begin m_lock = 0; m_err = 1'b0; end
      else if (m_lock == 0) begin if (d == 8'hA5) m_lock = 1; end
      else if (m_lock == 1) m_lock = (d == 8'h5A) ? 2 : 0;
    end
    exp_dout = {(phase(t) != 0), m_err, (m_lock == 2), 5'b0};
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("we_b", {4'h0, we_b}, {4'h0, exp_we});
      check("dout", dout, exp_dout);
      check("dout_en", {7'd0, dout_en},
            {7'd0, (!ioreq_b && !rd_b && (a[15:8] == 8'hDD))});
    end
  end

  // Pulse / busy monitor used by the directed scenarios.
  int low_cnt = 0, pulses = 0, busy_cnt = 0;
  logic [3:0] prev_we = 4'hF, low_val = 4'hF;
  initial forever begin
    @(negedge clk);
    if (reset_b) begin
      if (we_b != 4'hF) begin low_cnt++; low_val = we_b; end
      if (we_b != 4'hF && prev_we == 4'hF) pulses++;
      if (dout[7]) busy_cnt++;
    end
    prev_we = we_b;
  end

  task automatic clr_mon();
    low_cnt = 0; pulses = 0; busy_cnt = 0; low_val = 4'hF;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic io_wr(input logic [7:0] v);
    a = {8'hDD, 8'($urandom)}; d = v; ioreq_b = 1'b0; wr_b = 1'b0;
    cyc(2);
    ioreq_b = 1'b1; wr_b = 1'b1;
    cyc(1);
  endtask

  task automatic io_rd();
    a = {8'hDD, 8'($urandom)}; ioreq_b = 1'b0; rd_b = 1'b0;
    cyc(2);
    ioreq_b = 1'b1; rd_b = 1'b1;
    cyc(1);
  endtask

  task automatic mem_wr(input logic [15:0] ad, input int hold);
    a = ad; d = 8'($urandom); mreq_b = 1'b0; wr_b = 1'b0;
    cyc(hold);
    mreq_b = 1'b1; wr_b = 1'b1;
    cyc(1);
  endtask

  initial begin
    int r, g;
    logic [15:0] ad;
    reset_b = 1'b0;
    cyc(1);
    chk_on = 1'b1;
    cyc(2);
    check("reset_we_b", {4'h0, we_b}, 8'h0F);
    check("reset_dout", dout, 8'h00);
    check("reset_dout_en", {7'd0, dout_en}, 8'h00);
    reset_b = 1'b1;
    cyc(2);

    // Locked board ignores memory writes.
    rom_sel = 4'd3; sel_valid = 1'b1;
    clr_mon();
    mem_wr(16'hC123, 2);
    cyc(5);
    check("locked_no_pulse", 8'(pulses), 8'd0);
    check("locked_dout", dout, 8'h00);

    io_wr(8'hA5);
    io_wr(8'h5A);
    check("unlock_dout", dout, 8'h20);

    // Single byte: pulse on pair 1, full busy span.
    clr_mon();
    mem_wr(16'hC000, 2);
    cyc(WE + PT + WC + 20);
    check("single_low_val", {4'h0, low_val}, 8'h0D);
    check("single_low_cnt", 8'(low_cnt), 8'd2);
    check("single_busy_len", 8'(busy_cnt == 2 + 400 + 1000), 8'd1);
    check("single_end_dout", dout, 8'h20);

    // Three bytes of one page, 100 cycles apart.
    clr_mon();
    mem_wr(16'hC040, 2); cyc(97);
    mem_wr(16'hC041, 2); cyc(97);
    mem_wr(16'hC07F, 2);
    cyc(WE + PT + WC + 20);
    check("page_pulses", 8'(pulses), 8'd3);
    check("page_low_cnt", 8'(low_cnt), 8'd6);
    check("page_busy_len", 8'(busy_cnt == 200 + 2 + 400 + 1000), 8'd1);
    check("page_end_dout", dout, 8'h20);

    // Foreign page during LOAD flags an error; &00 clears it and relocks.
    clr_mon();
    mem_wr(16'hC000, 2); cyc(50);
    mem_wr(16'hC080, 2); cyc(2);
    check("badpage_pulses", 8'(pulses), 8'd1);
    check("badpage_dout", dout, 8'hE0);
    io_wr(8'h00);
    check("relock_dout", dout, 8'h80);
    cyc(PT + WC + 10);
    check("relock_idle_dout", dout, 8'h00);

    // Wrong second key relocks.
    io_wr(8'hA5);
    io_wr(8'h11);
    check("badkey_dout", dout, 8'h00);
    io_wr(8'hA5);
    io_wr(8'h5A);

    // Reset in the middle of a pulse.
    rom_sel = 4'd0;
    a = 16'hC000; mreq_b = 1'b0; wr_b = 1'b0;
    cyc(2);
    check("midpulse_we_b", {4'h0, we_b}, 8'h0E);
    reset_b = 1'b0; mreq_b = 1'b1; wr_b = 1'b1;
    cyc(1);
    check("reset_mid_we_b", {4'h0, we_b}, 8'h0F);
    check("reset_mid_dout", dout, 8'h00);
    reset_b = 1'b1;
    cyc(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 10) begin
        io_wr(8'hA5); io_wr(8'h5A);
      end else if (r < 14) begin
        io_wr(8'h00);
      end else if (r < 18) begin
        io_wr(($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom));
      end else if (r < 28) begin
        io_rd();
      end else if (r < 30) begin
        reset_b = 1'b0; cyc($urandom_range(1, 2)); reset_b = 1'b1; cyc(1);
      end else begin
        if ($urandom_range(0, 9) < 3) rom_sel = 4'($urandom_range(0, 7));
        sel_valid = ($urandom_range(0, 9) != 0);
        ad = {2'b11, 8'($urandom_range(0, 2)), 6'($urandom)};
        if ($urandom_range(0, 9) == 0) ad[15:14] = 2'($urandom_range(0, 2));
        mem_wr(ad, $urandom_range(1, 2));
      end
      g = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 8) : $urandom_range(100, 450);
      cyc(g);
    end
    cyc(WE + PT + WC + 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cpc_eeprom_write_seq.md
# cpc_eeprom_write_seq

In-system programming sequencer for the eight-ROM board's 28C256 EEPROM pairs. It sits downstream of the ROM-select latch and consumes the latched ROM number and its on-board flag. It snoops Z80 memory writes to the upper ROM window (&C000–&FFFF) and, only after an I/O unlock sequence, converts each write into a clean, fixed-width write-enable pulse on the selected EEPROM. It enforces the 28C256 page-load window and write-cycle time, and reports busy/error status on an I/O read.

## Interface
- PORT_HI, 8'hDD: A[15:8] value decoding the unlock/status I/O port
- WE_CYCLES, 2: width of the write-enable low pulse in CLK cycles (1..15)
- PAGE_TIMEOUT, 400: byte-load window in CLK cycles (100 µs at 4 MHz)
- WRITE_CYCLES, 40000: internal programming time in CLK cycles (10 ms at 4 MHz)

Ports:
- CLK  in  1  CPC bus clock (4 MHz)
- RESET_B  in  1  reset; synchronous, active-low
- A  in  16  Z80 address bus
- D  in  8  Z80 data bus (write data)
- MREQ_B, IOREQ_B, RD_B, WR_B  in  1 each  Z80 strobes, active-low
- rom_sel  in  4  latched ROM number from the ROM-select latch
- sel_valid  in  1  high when rom_sel addresses this board
- we_b  out  4  per-pair EEPROM write enable, active-low; index = rom_sel[2:1]
- dout  out  8  status byte
- dout_en  out  1  high while the status port is being read

## Operation
- **Lock FSM** (LOCKED, HALF, OPEN). An I/O write is IOREQ_B=0, WR_B=0, A[15:8]=PORT_HI; it acts on its first qualifying cycle only.
  - LOCKED + D=&A5 → HALF.
  - HALF + D=&5A → OPEN; HALF + any other value → LOCKED.
  - Any state + D=&00 → LOCKED, and err clears.
  - Other values in OPEN: ignored.
- **Memory write detect.** MREQ_B=0, WR_B=0, A[15:14]=2'b11, sel_valid=1. It is rising-edge qualified: it acts on the first cycle the condition is true after a cycle where it was false.
- **Write FSM** (IDLE, PULSE, LOAD, PROG):
  - IDLE: detect with lock=OPEN → capture page=A[13:6] and pair=rom_sel[2:1]; go to PULSE. Detect while not OPEN → ignored, no error.
  - PULSE: we_b[pair]=0 for WE_CYCLES cycles, then LOAD with the timeout counter reloaded to PAGE_TIMEOUT.
  - LOAD:
    - Detect with matching page and pair → PULSE; the counter reloads after that pulse.
    - Detect with a different page or pair → ignored, err=1, counter not reloaded.
    - Counter reaching 0 → PROG with the counter loaded to WRITE_CYCLES.
  - PROG: all detects are ignored and set err=1. Counter reaching 0 → IDLE.
- Relocking (&00) during PULSE/LOAD/PROG does not abort the sequence. The current pulse completes, LOAD/PROG time out normally, and no further bytes are accepted in LOAD.
- The captured page and pair are only updated from IDLE.
- **Status:** dout = {busy, err, lock==OPEN, 5'b0}, where busy = state≠IDLE. dout_en = IOREQ_B=0 & RD_B=0 & A[15:8]=PORT_HI (combinational); dout is registered.
- Counters are 16-bit and down-counting; a counter value of 0 is never reloaded with 0.

## Timing
- Reset values: we_b=4'hF, dout=8'h00, dout_en=0 while the bus is idle, lock=LOCKED, state=IDLE, err=0, counters=0.
- Reset asserted mid-operation aborts immediately on the next CLK edge: we_b high, state IDLE, lock LOCKED.
- Detect sampled at edge N → we_b[pair] low from edge N+1 through edge N+WE_CYCLES, high at edge N+WE_CYCLES+1. we_b is registered with no glitches and only one bit is low at a time.
- LOAD lasts PAGE_TIMEOUT cycles after the last pulse ends; PROG lasts WRITE_CYCLES cycles; busy drops the cycle IDLE is entered.
- A detect on the same edge that PULSE ends is accepted as the next byte (stays in PULSE for a new WE_CYCLES).
- A detect on the same edge the LOAD timeout expires is ignored and sets err.
- Lock writes are effective from the following cycle.

## Test plan
- Reset → we_b=F, dout=&00; write &A5, &5A to &DDxx → dout bit5=1.
- Locked board: memory write &C123 with rom_sel=3 → we_b stays F, err=0.
- Unlocked: write &C000, rom_sel=3, WE_CYCLES=2 → we_b=4'b1101 for exactly 2 cycles; busy=1 for 2+400+40000 cycles.
- Unlocked: three writes &C040/&C041/&C07F spaced 100 cycles → three pulses, a single PROG, err=0.
- In LOAD, write &C080 (different page) → no pulse, err=1; &00 to port → err=0, lock=LOCKED.
- Sequences &A5, &11 → LOCKED; RESET_B low mid-PULSE → we_b=F on the next edge, dout=&00.
